// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared constants and types for the EX-stage hazard controller:
// forwarding-select encodings, FSM states and a saturating increment.
package hazard_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int FCNT_W     = 3;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Pipeline <-> hazard-controller bundle: decode/EX fields in, stall,
// flush, redirect and forwarding selects out.
interface ex_hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
);

  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_branch;
  logic              ex_taken;
  logic              ex_j;
  logic              ex_jalr;

  logic              stall_pc;
  logic              stall_ifid;
  logic              flush_ifid;
  logic              flush_idex;
  logic              redirect;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread,
    output ex_branch, ex_taken, ex_j, ex_jalr,
    input  stall_pc, stall_ifid, flush_ifid, flush_idex, redirect,
    input  fwd_a, fwd_b, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread,
    input  ex_branch, ex_taken, ex_j, ex_jalr,
    output stall_pc, stall_ifid, flush_ifid, flush_idex, redirect,
    output fwd_a, fwd_b, perf_stall_cnt, perf_flush_cnt
  );

endinterface

// File: rtl/ex_hazard_ctrl_fwd_sel.sv
// Per-operand forwarding select: MEM beats WB, x0 never forwards, and a
// load in MEM has no ALU result to forward.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] ex_rs_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_we_i,
  input  logic              mem_ld_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_we_i,
  output logic [1:0]        sel_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_we_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i) && !mem_ld_i;
  assign wb_hit  = wb_we_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs_i);

  always_comb begin
    if (mem_hit)     sel_o = FWD_MEM;
    else if (wb_hit) sel_o = FWD_WB;
    else             sel_o = FWD_REG;
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: forwarding, load-use stall, redirect flush.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module ex_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int REG_AW       = REG_AW_DEF
) (
  input logic              clk,
  input logic              rst_n,
  ex_hazard_ctrl_if.slave  hz
);

  localparam logic [FCNT_W-1:0] FLUSH_LOAD = FLUSH_CYCLES[FCNT_W-1:0];

  state_e            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic [REG_AW-1:0] mem_rd_q, wb_rd_q;
  logic              mem_we_q, mem_ld_q, wb_we_q;

  logic              take;
  logic              load_use;
  logic              stall_c;
  logic              flush_ifid_c;
  logic              flush_idex_c;
  logic              redirect_c;

  // Shadow of the downstream pipeline; squashed slots arrive as zeros.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_q <= '0;
      mem_we_q <= 1'b0;
      mem_ld_q <= 1'b0;
      wb_rd_q  <= '0;
      wb_we_q  <= 1'b0;
    end else begin
      mem_rd_q <= hz.ex_rd;
      mem_we_q <= hz.ex_regwrite;
      mem_ld_q <= hz.ex_memread;
      wb_rd_q  <= mem_rd_q;
      wb_we_q  <= mem_we_q;
    end
  end

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_rs_i  (hz.ex_rs1),
    .mem_rd_i (mem_rd_q),
    .mem_we_i (mem_we_q),
    .mem_ld_i (mem_ld_q),
    .wb_rd_i  (wb_rd_q),
    .wb_we_i  (wb_we_q),
    .sel_o    (hz.fwd_a)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_rs_i  (hz.ex_rs2),
    .mem_rd_i (mem_rd_q),
    .mem_we_i (mem_we_q),
    .mem_ld_i (mem_ld_q),
    .wb_rd_i  (wb_rd_q),
    .wb_we_i  (wb_we_q),
    .sel_o    (hz.fwd_b)
  );

  assign take     = (hz.ex_branch && hz.ex_taken) || hz.ex_j || hz.ex_jalr;
  assign load_use = hz.ex_memread && (hz.ex_rd != '0) &&
                    ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    stall_c      = 1'b0;
    flush_ifid_c = 1'b0;
    flush_idex_c = 1'b0;
    redirect_c   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (take) begin
          redirect_c   = 1'b1;
          flush_ifid_c = 1'b1;
          flush_idex_c = 1'b1;
          if (FLUSH_CYCLES != 0) begin
            state_d = ST_FLUSH;
            fcnt_d  = FLUSH_LOAD;
          end
        end else if (load_use) begin
          stall_c      = 1'b1;
          flush_idex_c = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Redirected fetch still in flight: squash whatever IF/ID and ID/EX hold.
        flush_ifid_c = 1'b1;
        flush_idex_c = 1'b1;
        fcnt_d       = fcnt_q - FCNT_W'(1);
        if (fcnt_q == FCNT_W'(1)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Inputs may be live during reset; gate so the pipeline sees all-quiet controls.
  assign hz.stall_pc   = rst_n & stall_c;
  assign hz.stall_ifid = rst_n & stall_c;
  assign hz.flush_ifid = rst_n & flush_ifid_c;
  assign hz.flush_idex = rst_n & flush_idex_c;
  assign hz.redirect   = rst_n & redirect_c;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_c)    stall_cnt_q <= sat_inc(stall_cnt_q);
      if (redirect_c) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign hz.perf_stall_cnt = stall_cnt_q;
  assign hz.perf_flush_cnt = flush_cnt_q;
`else
  assign hz.perf_stall_cnt = '0;
  assign hz.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed hazard scenarios plus random traffic,
// compared every cycle against a behavioural model of the pipeline rules.
module tb_ex_hazard_ctrl;
  import hazard_pkg::*;

  localparam int FC = 2;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_hazard_ctrl_if #(.REG_AW(AW)) bus ();

  ex_hazard_ctrl #(.FLUSH_CYCLES(FC), .REG_AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus)
  );

  typedef struct packed {
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic [4:0] ex_rd;
    logic       ex_regwrite;
    logic       ex_memread;
    logic       ex_branch;
    logic       ex_taken;
    logic       ex_j;
    logic       ex_jalr;
  } stim_t;

  typedef struct packed {
    logic       stall_pc;
    logic       stall_ifid;
    logic       flush_ifid;
    logic       flush_idex;
    logic       redirect;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
  } obs_t;

  int checks = 0;
  int errors = 0;

  // Model: the last two instructions that left EX, and remaining flush slots.
  logic [4:0] hist_rd [2];
  bit         hist_we [2];
  bit         hist_ld [2];
  int         flush_left;
  longint     stall_m, flush_m;
  obs_t       last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cap32(input longint v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      hist_rd[i] = '0;
      hist_we[i] = 1'b0;
      hist_ld[i] = 1'b0;
    end
    flush_left = 0;
    stall_m    = 0;
    flush_m    = 0;
  endtask

  // hist[0] is the instruction one slot ahead (MEM), hist[1] two ahead (WB).
  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    if (hist_we[0] && !hist_ld[0] && hist_rd[0] == rs) return 2'b01;
    if (hist_we[1] && hist_rd[1] == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit is_take(input stim_t s);
    return (s.ex_branch && s.ex_taken) || s.ex_j || s.ex_jalr;
  endfunction

  function automatic bit is_lu(input stim_t s);
    return s.ex_memread && s.ex_rd != 0 &&
           ((s.id_use_rs1 && s.id_rs1 == s.ex_rd) || (s.id_use_rs2 && s.id_rs2 == s.ex_rd));
  endfunction

  function automatic obs_t model_out(input stim_t s);
    obs_t o;
    o = '0;
    o.fwd_a = model_fwd(s.ex_rs1);
    o.fwd_b = model_fwd(s.ex_rs2);
    if (flush_left > 0) begin
      o.flush_ifid = 1'b1;
      o.flush_idex = 1'b1;
    end else if (is_take(s)) begin
      o.redirect   = 1'b1;
      o.flush_ifid = 1'b1;
      o.flush_idex = 1'b1;
    end else if (is_lu(s)) begin
      o.stall_pc   = 1'b1;
      o.stall_ifid = 1'b1;
      o.flush_idex = 1'b1;
    end
    return o;
  endfunction

  task automatic model_advance(input stim_t s);
    if (flush_left > 0) flush_left--;
    else if (is_take(s)) begin
      flush_left = FC;
      flush_m++;
    end else if (is_lu(s)) stall_m++;
    hist_rd[1] = hist_rd[0];
    hist_we[1] = hist_we[0];
    hist_ld[1] = hist_ld[0];
    hist_rd[0] = s.ex_rd;
    hist_we[0] = s.ex_regwrite;
    hist_ld[0] = s.ex_memread;
  endtask

  task automatic drive(input stim_t s);
    bus.id_rs1      = s.id_rs1;
    bus.id_rs2      = s.id_rs2;
    bus.id_use_rs1  = s.id_use_rs1;
    bus.id_use_rs2  = s.id_use_rs2;
    bus.ex_rs1      = s.ex_rs1;
    bus.ex_rs2      = s.ex_rs2;
    bus.ex_rd       = s.ex_rd;
    bus.ex_regwrite = s.ex_regwrite;
    bus.ex_memread  = s.ex_memread;
    bus.ex_branch   = s.ex_branch;
    bus.ex_taken    = s.ex_taken;
    bus.ex_j        = s.ex_j;
    bus.ex_jalr     = s.ex_jalr;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.stall_pc   = bus.stall_pc;
    o.stall_ifid = bus.stall_ifid;
    o.flush_ifid = bus.flush_ifid;
    o.flush_idex = bus.flush_idex;
    o.redirect   = bus.redirect;
    o.fwd_a      = bus.fwd_a;
    o.fwd_b      = bus.fwd_b;
    return o;
  endfunction

  task automatic check_perf(input string tag);
`ifdef HAZARD_PERF_CNT_EN
    check({tag, ".perf_stall"}, bus.perf_stall_cnt, cap32(stall_m));
    check({tag, ".perf_flush"}, bus.perf_flush_cnt, cap32(flush_m));
`else
    check({tag, ".perf_stall"}, bus.perf_stall_cnt, 32'd0);
    check({tag, ".perf_flush"}, bus.perf_flush_cnt, 32'd0);
`endif
  endtask

  // One pipeline cycle: drive after negedge, compare mid-low-phase, advance model at posedge.
  task automatic step(input stim_t s, input string tag);
    obs_t e;
    @(negedge clk);
    drive(s);
    #2;
    e    = model_out(s);
    last = sample();
    check({tag, ".stall_pc"},   last.stall_pc,   e.stall_pc);
    check({tag, ".stall_ifid"}, last.stall_ifid, e.stall_ifid);
    check({tag, ".flush_ifid"}, last.flush_ifid, e.flush_ifid);
    check({tag, ".flush_idex"}, last.flush_idex, e.flush_idex);
    check({tag, ".redirect"},   last.redirect,   e.redirect);
    check({tag, ".fwd_a"},      last.fwd_a,      e.fwd_a);
    check({tag, ".fwd_b"},      last.fwd_b,      e.fwd_b);
    check_perf(tag);
    @(posedge clk);
    model_advance(s);
  endtask

  task automatic check_all_zero(input string tag);
    obs_t o;
    o = sample();
    check({tag, ".ctrl"}, 32'(o), 32'd0);
    check({tag, ".perf_stall"}, bus.perf_stall_cnt, 32'd0);
    check({tag, ".perf_flush"}, bus.perf_flush_cnt, 32'd0);
  endtask

  function automatic stim_t busy_stim();
    stim_t s;
    s = '0;
    s.ex_branch   = 1'b1;
    s.ex_taken    = 1'b1;
    s.ex_memread  = 1'b1;
    s.ex_regwrite = 1'b1;
    s.ex_rd       = 5'd3;
    s.id_rs1      = 5'd3;
    s.id_use_rs1  = 1'b1;
    s.ex_rs1      = 5'd3;
    s.ex_rs2      = 5'd3;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.id_rs1      = 5'($urandom_range(0, 3));
    s.id_rs2      = 5'($urandom_range(0, 3));
    s.id_use_rs1  = 1'($urandom_range(0, 1));
    s.id_use_rs2  = 1'($urandom_range(0, 1));
    s.ex_rs1      = 5'($urandom_range(0, 3));
    s.ex_rs2      = 5'($urandom_range(0, 3));
    s.ex_rd       = 5'($urandom_range(0, 3));
    s.ex_regwrite = 1'($urandom_range(0, 1));
    s.ex_memread  = ($urandom_range(0, 2) == 0);
    s.ex_branch   = ($urandom_range(0, 7) == 0);
    s.ex_taken    = 1'($urandom_range(0, 1));
    s.ex_j        = ($urandom_range(0, 15) == 0);
    s.ex_jalr     = ($urandom_range(0, 15) == 0);
    return s;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;

    rst_n = 1'b0;
    drive(busy_stim());
    model_reset();
    #3;
    check_all_zero("reset");
    @(negedge clk);
    drive('0);
    #3 rst_n = 1'b1;

    // Back-to-back dependence: MEM forward then WB forward, no stall.
    s = '0; s.ex_rd = 5'd5; s.ex_regwrite = 1'b1;
    step(s, "b2b_n");
    s = '0; s.ex_rs1 = 5'd5;
    step(s, "b2b_n1");
    check("b2b_fwd_a_lit", last.fwd_a, 2'b01);
    s = '0; s.ex_rs2 = 5'd5;
    step(s, "b2b_n2");
    check("b2b_fwd_b_lit", last.fwd_b, 2'b10);
    check("b2b_stall_lit", last.stall_pc, 1'b0);

    // x0 guard.
    s = '0; s.ex_rd = 5'd0; s.ex_regwrite = 1'b1;
    step(s, "x0_w");
    s = '0; s.ex_rs1 = 5'd0;
    step(s, "x0_r");
    check("x0_fwd_a_lit", last.fwd_a, 2'b00);

    // Load-use: one stall cycle, then the bubble clears it.
    s = '0; s.ex_memread = 1'b1; s.ex_regwrite = 1'b1; s.ex_rd = 5'd7;
    s.id_rs2 = 5'd7; s.id_use_rs2 = 1'b1;
    step(s, "lu_hit");
    check("lu_stall_pc_lit", last.stall_pc, 1'b1);
    check("lu_stall_ifid_lit", last.stall_ifid, 1'b1);
    check("lu_flush_idex_lit", last.flush_idex, 1'b1);
    s = '0; s.id_rs2 = 5'd7; s.id_use_rs2 = 1'b1;
    step(s, "lu_bubble");
    check("lu_clear_lit", last.stall_pc, 1'b0);

    // Taken branch: redirect once, IF/ID flushed for 1 + FC cycles, load-use ignored.
    s = '0; s.ex_branch = 1'b1; s.ex_taken = 1'b1;
    step(s, "br_take");
    check("br_redirect_lit", last.redirect, 1'b1);
    s = '0; s.ex_memread = 1'b1; s.ex_rd = 5'd9; s.id_rs1 = 5'd9; s.id_use_rs1 = 1'b1;
    for (int i = 0; i < FC; i++) begin
      step(s, "br_flush");
      check("br_flush_ifid_lit", last.flush_ifid, 1'b1);
      check("br_nostall_lit", last.stall_pc, 1'b0);
      check("br_noredir_lit", last.redirect, 1'b0);
    end
    step('0, "br_done");
    check("br_done_lit", last.flush_ifid, 1'b0);

    // Jalr colliding with load-use.
    s = '0; s.ex_jalr = 1'b1; s.ex_memread = 1'b1; s.ex_regwrite = 1'b1;
    s.ex_rd = 5'd7; s.id_rs1 = 5'd7; s.id_use_rs1 = 1'b1;
    step(s, "jalr_lu");
    check("jalr_redirect_lit", last.redirect, 1'b1);
    check("jalr_stall_lit", last.stall_pc, 1'b0);
    for (int i = 0; i < FC; i++) step('0, "jalr_flush");

    // Reset asserted mid-FLUSH.
    s = '0; s.ex_j = 1'b1;
    step(s, "rst_j");
    @(negedge clk);
    drive(busy_stim());
    #1;
    check("rst_pre_flush_lit", bus.flush_ifid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid_flush");
    model_reset();
    @(negedge clk);
    drive('0);
    #3 rst_n = 1'b1;
    s = '0; s.ex_rs1 = 5'd3; s.ex_rs2 = 5'd3;
    step(s, "rst_after");
    check("rst_after_fwd_lit", {last.fwd_a, last.fwd_b}, 4'b0000);
    check("rst_after_run_lit", last.flush_ifid, 1'b0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) step(rand_stim(), "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
